// File: rtl/vector_fetch.sv
// Pops a vector address, issues a BURST_LEN read burst, and writes each beat (optionally byte-swapped) to the vector FIFO one cycle after arrival.
// Holds the request until acked; only starts with BURST_LEN words free. Optional watchdog: `define VECTOR_FETCH_TIMEOUT_EN.
module vector_fetch #(
  parameter int BURST_LEN       = 8,
  parameter int VCTR_FIFO_DEPTH = 1024,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_program,
  input  logic        vector_byte_swap,
  input  logic        addr_fifo_empty,
  output logic        addr_fifo_rd,
  input  logic [31:0] addr_fifo_dout,
  output logic        master_rd,
  output logic [31:0] master_addr,
  output logic [8:0]  master_len,
  input  logic        master_rd_ack,
  input  logic [31:0] master_data_in,
  input  logic        master_data_in_val,
  input  logic [15:0] words_in_vctr_fifo,
  output logic        vctr_fifo_wr,
  output logic [31:0] vctr_fifo_din,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic [31:0] bursts_fetched,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, POP, LATCH, REQ, DATA} state_t;
  localparam int BCW = $clog2(BURST_LEN) + 1;

  state_t         state, state_nxt;
  logic [BCW-1:0] beat_cnt;
  logic           ack_vld, beat_vld, last_beat, space_ok, timeout_hit;
  logic [16:0]    occ_need;

  assign ack_vld   = (state == REQ) && master_rd_ack;
  assign beat_vld  = (state == DATA) && master_data_in_val;
  assign last_beat = beat_vld && (beat_cnt == BCW'(BURST_LEN - 1));

  // The write still in flight is counted so the check sees post-write occupancy.
  assign occ_need = {1'b0, words_in_vctr_fifo} + {16'd0, vctr_fifo_wr} + 17'(BURST_LEN);
  assign space_ok = (occ_need <= 17'(VCTR_FIFO_DEPTH));

  assign addr_fifo_rd = (state == POP);
  assign master_rd    = (state == REQ);
  assign fetch_busy   = (state != IDLE);
  assign master_len   = 9'(BURST_LEN);

`ifdef VECTOR_FETCH_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] wd_cnt;
  logic           wd_run, err_q;

  // Any ack or beat counts as progress and restarts the watchdog.
  assign wd_run      = ((state == REQ) || (state == DATA)) && !ack_vld && !beat_vld;
  assign timeout_hit = wd_run && (wd_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wd_run && !timeout_hit) wd_cnt <= wd_cnt + 1'b1;
      else                        wd_cnt <= '0;
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run_program && !addr_fifo_empty && space_ok && !timeout_err) state_nxt = POP;
      POP:     state_nxt = LATCH;
      LATCH:   state_nxt = REQ;
      REQ:     if (ack_vld) state_nxt = DATA;
      DATA:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      master_addr    <= '0;
      beat_cnt       <= '0;
      vctr_fifo_wr   <= 1'b0;
      vctr_fifo_din  <= '0;
      fetch_done     <= 1'b0;
      bursts_fetched <= '0;
    end else begin
      vctr_fifo_wr <= beat_vld;
      fetch_done   <= last_beat;
      if (state == LATCH) master_addr <= addr_fifo_dout;
      if (state != DATA)  beat_cnt <= '0;
      else if (beat_vld)  beat_cnt <= beat_cnt + 1'b1;
      if (beat_vld) begin
        vctr_fifo_din <= vector_byte_swap
          ? {master_data_in[7:0], master_data_in[15:8], master_data_in[23:16], master_data_in[31:24]}
          : master_data_in;
      end
      if (last_beat) bursts_fetched <= bursts_fetched + 32'd1;
    end
  end

endmodule
